// File: rtl/dec4_16_scan_ctrl_pkg.sv
// dec_scan_pkg: shared types, sizes and row-search helper for the decoder row-scan sequencer
package dec_scan_pkg;
  localparam int ROW_W = 4;
  localparam int NUM_ROWS = 16;
  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} scan_state_t;
  // Lowest unmasked row in [from, last]; MSB flags that one exists. A 5-bit start lets row+1 reach 16.
  function automatic logic [ROW_W:0] find_row(input logic [NUM_ROWS-1:0] mask, input logic [ROW_W:0] from,
                                               input logic [ROW_W-1:0] last);
    find_row = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--)
      if (i >= int'(from) && i <= int'(last) && !mask[i]) find_row = {1'b1, ROW_W'(i)};
  endfunction
endpackage

// File: rtl/dec4_16_scan_ctrl_timer.sv
// scan_timer: loadable down-counter whose registered last_o is high in the final counted cycle
// Ports: clk, rst_n (async, active-low); load/val restart the count at val (0 = idle, never last);
//        last_o marks the cycle in which the count reads 1.
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         last_o
);
  logic [W-1:0] cnt_q;
  logic         last_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      cnt_q  <= load ? val : cnt_q - W'(cnt_q != '0);
      // Flag is precomputed one cycle early so last_o is a plain flop
      last_q <= load ? (val == W'(1)) : ({1'b0, cnt_q} == (W + 1)'(2));
    end
  assign last_o = last_q;
endmodule

// File: rtl/dec4_16_scan_ctrl.sv
// dec4_16_scan_ctrl: row-scan sequencer driving address and enables of a shared 4-to-16 decoder
// Ports: clk, rst_n (async, active-low); start/stop handshake; cont, dwell, last_row latched on start;
//        dec_x/dec_e1/dec_e0_l drive the decoder; row_stb marks the last enabled cycle of a row;
//        busy while scanning; done pulses once after a single frame.
// Option: DEC_SCAN_SKIP_EN adds skip_mask so masked rows are passed over without blanking or driving.
module dec4_16_scan_ctrl import dec_scan_pkg::*; #(
  parameter int DWELL_W   = 8,
  parameter int BLANK_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cont,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [ROW_W-1:0]   last_row,
`ifdef DEC_SCAN_SKIP_EN
  input  logic [NUM_ROWS-1:0] skip_mask,
`endif
  output logic [ROW_W-1:0]   dec_x,
  output logic               dec_e1,
  output logic               dec_e0_l,
  output logic               row_stb,
  output logic               busy,
  output logic               done
);
  // At least two bits so the timer's "next is last" compare stays meaningful
  localparam int BW = (BLANK_CYC < 2) ? 2 : $clog2(BLANK_CYC + 1);
  scan_state_t         state_q, state_d, ent;
  logic [ROW_W-1:0]    row_q, row_d, last_q;
  logic [DWELL_W-1:0]  dwell_q, dw_eff, dw_val;
  logic [BW-1:0]       blk_val;
  logic [ROW_W:0]      init, nxt, wrap;
  logic [NUM_ROWS-1:0] mask, in_mask;
  logic cont_q, e1_q, e0l_q, busy_q, done_q, done_d, accept, dw_ld, blk_ld, dw_last, blk_last;
`ifdef DEC_SCAN_SKIP_EN
  logic [NUM_ROWS-1:0] mask_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mask_q <= '0;
    else if (accept) mask_q <= skip_mask;
  assign mask    = mask_q;
  assign in_mask = skip_mask;
`else
  assign mask    = '0;
  assign in_mask = '0;
`endif
  assign accept = state_q == IDLE && start && !stop;
  // Dwell of 0 behaves as 1; the input is used directly on the accepting edge
  assign dw_eff = state_q == IDLE ? (|dwell ? dwell : DWELL_W'(1)) : dwell_q;
  always_comb begin
    init    = find_row(in_mask, '0, last_row);
    nxt     = find_row(mask, {1'b0, row_q} + (ROW_W + 1)'(1), last_q);
    wrap    = find_row(mask, '0, last_q);
    ent     = BLANK_CYC == 0 ? DRIVE : BLANK;
    state_d = state_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (accept) begin
        row_d   = init[ROW_W-1:0];
        // With nothing to scan, park in BLANK on a masked row so the dead-frame rule below applies
        state_d = init[ROW_W] ? ent : BLANK;
      end
      BLANK:
        if (mask[row_q]) begin
          state_d = cont_q ? BLANK : IDLE;
          done_d  = !cont_q;
        end else if (blk_last) state_d = DRIVE;
      DRIVE: if (dw_last) begin
        state_d = (nxt[ROW_W] || cont_q) ? ent : IDLE;
        row_d   = nxt[ROW_W] ? nxt[ROW_W-1:0] : wrap[ROW_W-1:0];
        done_d  = !nxt[ROW_W] && !cont_q;
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
    if (state_d == IDLE) row_d = '0;
    // Timers are held at zero outside their own state so their last flags double as outputs
    dw_ld   = state_d != DRIVE || state_q != DRIVE || dw_last;
    dw_val  = state_d == DRIVE ? dw_eff : '0;
    blk_ld  = state_d != BLANK || state_q != BLANK;
    blk_val = state_d == BLANK ? BW'(BLANK_CYC) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      cont_q  <= 1'b0;
      e1_q    <= 1'b0;
      e0l_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      e1_q    <= state_d == DRIVE;
      e0l_q   <= state_d != DRIVE;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
      if (accept) begin
        last_q  <= last_row;
        dwell_q <= dw_eff;
        cont_q  <= cont;
      end
    end
  scan_timer #(.W(DWELL_W)) u_dwell (.clk(clk), .rst_n(rst_n), .load(dw_ld), .val(dw_val), .last_o(dw_last));
  scan_timer #(.W(BW)) u_blank (.clk(clk), .rst_n(rst_n), .load(blk_ld), .val(blk_val), .last_o(blk_last));
  assign dec_x    = row_q;
  assign dec_e1   = e1_q;
  assign dec_e0_l = e0l_q;
  assign row_stb  = dw_last;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_dec4_16_scan_ctrl.sv
// tb_dec4_16_scan_ctrl: directed scan scenarios checked against a frame-time arithmetic model
module tb_dec4_16_scan_ctrl;
  localparam int B = 2;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, cont = 0;
  logic [7:0] dwell = 0;
  logic [3:0] last_row = 0;
  logic [3:0] dec_x;
  logic dec_e1, dec_e0_l, row_stb, busy, done;
  int checks = 0, errors = 0;
  bit chk_en = 1;
`ifdef DEC_SCAN_SKIP_EN
  logic [15:0] skip_mask = 0;
`endif
  always #5 clk = ~clk;
  dec4_16_scan_ctrl #(.DWELL_W(8), .BLANK_CYC(B)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont), .dwell(dwell), .last_row(last_row),
`ifdef DEC_SCAN_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .dec_x(dec_x), .dec_e1(dec_e1), .dec_e0_l(dec_e0_l), .row_stb(row_stb), .busy(busy), .done(done));
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", name, got, exp, $time);
    end
  endtask
  // Model: t counts cycles since the first busy cycle; row and phase follow from the row period
  bit act = 0, cm = 0, m_done = 0;
  int t = 0, D = 1, L = 0, P = 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (stop) act = 0;
      else if (!act) begin
        if (start) begin
          act = 1; t = 0; D = (dwell == 0) ? 1 : int'(dwell); L = int'(last_row); cm = cont; P = B + D;
        end
      end else begin
        t++;
        if (!cm && t == (L + 1) * P) begin act = 0; m_done = 1; end
      end
    end
  always @(negedge clk)
    if (chk_en) begin
      int ph, ex, een, estb;
      ph = act ? t % P : 0;
      ex = act ? (t / P) % (L + 1) : 0;
      een = act && ph >= B;
      estb = een && ph == P - 1;
      chk("dec_x", dec_x, ex);
      chk("dec_e1", dec_e1, een);
      chk("dec_e0_l", dec_e0_l, !een);
      chk("row_stb", row_stb, estb);
      chk("busy", busy, act);
      chk("done", done, m_done);
    end
  task automatic frame(input int dw, input int lr, input bit c, input int n, input int rp,
                       output int en_cnt, output int stb_cnt, output int busy_cnt, output int done_at,
                       output int stb_at, output int xs);
    @(negedge clk);
    dwell = 8'(dw); last_row = 4'(lr); cont = c; start = 1;
    en_cnt = 0; stb_cnt = 0; busy_cnt = 0; done_at = -1; stb_at = -1; xs = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start = (k == rp);
      en_cnt += int'(dec_e1);
      busy_cnt += int'(busy);
      if (row_stb) begin stb_cnt++; stb_at = k; xs = xs * 16 + int'(dec_x); end
      if (done && done_at < 0) done_at = k;
    end
    start = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int en, stb, bz, da, sa, xs, dones, px;
    bit wrapped, stopped;
    repeat (2) @(negedge clk);
    chk("rst_e0_l", dec_e0_l, 1);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    frame(3, 2, 0, 20, 0, en, stb, bz, da, sa, xs);
    chk("f1_en_cycles", en, 9);
    chk("f1_stb", stb, 3);
    chk("f1_busy_cycles", bz, 15);
    chk("f1_done_cycle", da, 16);
    chk("f1_rows", xs, 'h012);
    frame(0, 0, 0, 6, 0, en, stb, bz, da, sa, xs);
    chk("f2_en_cycles", en, 1);
    chk("f2_stb_cycle", sa, 3);
    chk("f2_done_cycle", da, 4);
    frame(2, 1, 0, 12, 3, en, stb, bz, da, sa, xs);
    chk("f3_busy_cycles", bz, 8);
    chk("f3_done_cycle", da, 9);
    @(negedge clk); start = 1; stop = 1;
    @(negedge clk); start = 0; stop = 0;
    @(negedge clk);
    chk("ss_busy", busy, 0);
    @(negedge clk); dwell = 1; last_row = 15; cont = 1; start = 1;
    wrapped = 0; stopped = 0; dones = 0; px = 0;
    for (int k = 1; k <= 200 && !(stopped && stop == 0); k++) begin
      @(negedge clk);
      start = 0;
      if (stopped) begin
        stop = 0;
        chk("abort_e1", dec_e1, 0);
        chk("abort_e0_l", dec_e0_l, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
      end else begin
        dones += int'(done);
        if (busy && px == 15 && dec_x == 0) wrapped = 1;
        px = int'(dec_x);
        if (wrapped && dec_x == 5 && dec_e1) begin stop = 1; stopped = 1; end
      end
    end
    stop = 0;
    chk("cont_wrapped", int'(wrapped), 1);
    chk("cont_stop_reached", int'(stopped), 1);
    chk("cont_no_done", dones, 0);
    @(negedge clk); dwell = 4; last_row = 3; cont = 0; start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 10 && !dec_e1; k++) @(negedge clk);
    chk("mid_drive", dec_e1, 1);
    #2 rst_n = 0;
    #1;
    chk("async_e1", dec_e1, 0);
    chk("async_e0_l", dec_e0_l, 1);
    chk("async_busy", busy, 0);
    @(negedge clk); rst_n = 1;
    frame(1, 0, 0, 6, 0, en, stb, bz, da, sa, xs);
    chk("post_rst_en", en, 1);
    chk("post_rst_row", xs, 0);
    chk("post_rst_done", da, 4);
`ifdef DEC_SCAN_SKIP_EN
    chk_en = 0;
    skip_mask = 16'h0005;
    frame(1, 3, 0, 30, 0, en, stb, bz, da, sa, xs);
    chk("skip_stb", stb, 2);
    chk("skip_rows", xs, 'h13);
    chk("skip_en", en, 2);
    skip_mask = 0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dec4_16_scan_ctrl.md
# dec4_16_scan_ctrl

Row-scan sequencer for the shared 4-to-16 decoder (Dec4_16). It drives the decoder address `X` and both enables (`E1`, `E0_L`) to step through rows 0..`last_row`. Each row gets a fixed blanking gap and a programmable dwell time. It supports single-frame and continuous scanning, a start/stop handshake, and per-row sample strobes for downstream capture logic (key matrix or LED row drivers).

## Interface
- `DWELL_W`, default 8: width of the dwell-count input.
- `BLANK_CYC`, default 2: decoder-disabled cycles before each row; 0 is legal and means no blanking.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a frame; sampled only in IDLE.
- `stop`  in  1  abort request; honoured in any state.
- `cont`  in  1  continuous mode; sampled on the accepted `start`.
- `dwell`  in  DWELL_W  enabled cycles per row; sampled on the accepted `start`; 0 is treated as 1.
- `last_row`  in  4  final row of the frame; sampled on the accepted `start`.
- `dec_x`  out  4  decoder address, feeds `X`.
- `dec_e1`  out  1  decoder active-high enable.
- `dec_e0_l`  out  1  decoder active-low enable.
- `row_stb`  out  1  one-cycle pulse in the final DRIVE cycle of each row.
- `busy`  out  1  high while not in IDLE.
- `done`  out  1  one-cycle pulse at normal frame completion.

## Operation
- States: IDLE, BLANK, DRIVE.
- Decoder enabled means `dec_e1=1` and `dec_e0_l=0`. Decoder disabled means `dec_e1=0` and `dec_e0_l=1`. Outputs are enabled only in DRIVE.
- IDLE:
  - Outputs: `dec_x=0`, decoder disabled, `busy=0`.
  - `start=1` and `stop=0`: latch `dwell`, `last_row` and `cont`; set row=0; go to BLANK. If BLANK_CYC=0, go straight to DRIVE.
- BLANK:
  - `dec_x` already shows the current row; decoder disabled.
  - Stays BLANK_CYC cycles, then goes to DRIVE.
- DRIVE:
  - Decoder enabled for exactly `dwell_q` cycles; `row_stb` is asserted in the last of those cycles.
  - After the last cycle, if row < `last_q`: row+1, go to BLANK.
  - After the last cycle, if row == `last_q` and `cont_q=1`: row=0, go to BLANK (no `done`).
  - After the last cycle, if row == `last_q` and `cont_q=0`: go to IDLE and pulse `done` in the first IDLE cycle.
- `stop=1` in any state: go to IDLE next cycle. No `done`, no `row_stb` in the abort cycle, decoder disabled from that next cycle.
- `start` while busy is ignored. `start` and `stop` together in IDLE: `stop` wins and the block stays idle.
- Row counter is 4 bits. With `last_row=15` it wraps 15→0 only in continuous mode.
- All counters are down-counters loaded on state entry. Dwell counter is DWELL_W bits; blank counter is sized for BLANK_CYC.

## Timing
- Reset values: `dec_x=0`, `dec_e1=0`, `dec_e0_l=1`, `row_stb=0`, `busy=0`, `done=0`, state IDLE. Reset asserted mid-frame drops the enables immediately (asynchronous).
- Accepted `start` at cycle 0: `busy=1` from cycle 1; decoder enabled at cycle 1+BLANK_CYC.
- Row period is BLANK_CYC + `dwell_q` cycles.
- Single frame: `busy` lasts (`last_q`+1)×(BLANK_CYC+`dwell_q`) cycles. `done` coincides with the first cycle of `busy=0`.
- `dec_x` changes only on entry to BLANK (or DRIVE when BLANK_CYC=0), never while the decoder is enabled, so the decoder outputs are glitch-free.
- All outputs are registered.

## Configuration
- `DEC_SCAN_SKIP_EN` defined:
  - Adds input `skip_mask[15:0]`, sampled on the accepted `start`.
  - Masked rows are passed over with no BLANK, no DRIVE and no `row_stb`; the next unmasked row is found in one cycle.
  - If every row 0..`last_q` is masked: single mode pulses `done` two cycles after `start`; continuous mode stays busy with the decoder disabled until `stop`.
- `DEC_SCAN_SKIP_EN` undefined: no `skip_mask` port; every row is scanned.

## Structure
- Package `dec_scan_pkg`:
  - state enum `scan_state_t` (IDLE, BLANK, DRIVE);
  - `ROW_W=4`, `NUM_ROWS=16`.
- Sub-module `scan_timer`: loadable down-counter with a terminal-count flag. Instantiated once for dwell and once for blank.
- Top level holds the FSM, row counter and output registers.

## Test plan
- Reset then `start` with `dwell=3`, `last_row=2`, `cont=0`, BLANK_CYC=2 → `dec_x` steps 0,1,2; 3 enabled cycles per row; 3 `row_stb` pulses; `done` at cycle 16; `busy` high for cycles 1–15.
- `dwell=0`, `last_row=0` → a single enabled cycle, `row_stb` in that same cycle, then `done`.
- `cont=1`, `last_row=15`, `dwell=1` → `dec_x` wraps 15→0 with no `done`. `stop` during DRIVE of row 5 → decoder disabled next cycle, `busy=0`, no `done`.
- `start` pulsed during a frame → ignored, frame timing unchanged. `start` and `stop` together in IDLE → stays IDLE.
- Reset asserted mid-DRIVE → `dec_e1=0`, `dec_e0_l=1` asynchronously; the next `start` begins at row 0.
- With `DEC_SCAN_SKIP_EN`, `skip_mask=16'h0005`, `last_row=3` → only rows 1 and 3 are driven, 2 `row_stb` pulses.
